// File: rtl/spawn_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// spawn_scheduler_pkg
// Shared game definitions used by the spawn scheduler and the monster block:
//   MONSTERS     - number of monster slots (slot index fits in 4 bits)
//   LANE_*       - spawn lane encoding (up/down/left/right)
//   game_state_e - game phase encoding (idle, running, over)
//   LFSR_MASK    - feedback mask of the 16-bit Galois LFSR
// ---------------------------------------------------------------------------
package spawn_scheduler_pkg;

    localparam int MONSTERS = 12;

    typedef logic [1:0] lane_t;
    localparam lane_t LANE_UP    = 2'b00;
    localparam lane_t LANE_DOWN  = 2'b01;
    localparam lane_t LANE_LEFT  = 2'b10;
    localparam lane_t LANE_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_e;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

endpackage

// File: rtl/spawn_scheduler_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR (right-shifting). Steps on every clock, returns to SEED
// on reset. SEED must be nonzero or the register locks up at zero.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   o_state  current LFSR value
// ---------------------------------------------------------------------------
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = 16'hB400
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SEED;
        end else begin
            r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? MASK : 16'h0000);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/spawn_scheduler.sv
// ---------------------------------------------------------------------------
// spawn_scheduler
// Game-level controller: owns the game phase, generates the move_tick
// cadence, schedules monster spawns (slot by circular first-free search,
// lane from an LFSR) and tracks score / difficulty level.
// Ports:
//   clk_game     game clock
//   rst          synchronous active-high reset
//   start        pulse: start or restart a game (ignored while running)
//   kill         pulse: one monster killed (counted only while running)
//   hit          pulse: a monster reached the hero (ends a running game)
//   slot_busy    occupancy of each monster slot
//   active       high while the game is running
//   move_tick    one-cycle monster-advance strobe
//   spawn_valid  one-cycle spawn command, only ever in a move_tick cycle
//   spawn_slot   slot to spawn into (holds between spawns)
//   spawn_lane   lane to spawn on (holds between spawns)
//   score        kills this game, saturating
//   level        difficulty level, saturating at 15
//   dbg_state    current game phase (game_state_e encoding)
//
// spawn_valid is a fire-and-forget command: there is no ready. The monster
// block must accept it in the same cycle and mark the slot busy before the
// next move_tick, otherwise the slot may be chosen again.
// ---------------------------------------------------------------------------
module spawn_scheduler
    import spawn_scheduler_pkg::*;
#(
    parameter int          PERIOD_INIT     = 1000,
    parameter int          PERIOD_STEP     = 50,
    parameter int          PERIOD_MIN      = 200,
    parameter int          KILLS_PER_LEVEL = 8,
    parameter int          SPAWN_GAP       = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                clk_game,
    input  logic                rst,
    input  logic                start,
    input  logic                kill,
    input  logic                hit,
    input  logic [MONSTERS-1:0] slot_busy,
    output logic                active,
    output logic                move_tick,
    output logic                spawn_valid,
    output logic [3:0]          spawn_slot,
    output logic [1:0]          spawn_lane,
    output logic [15:0]         score,
    output logic [3:0]          level,
    output logic [1:0]          dbg_state
);

    localparam logic [1:0]  S_IDLE    = ST_IDLE;
    localparam logic [1:0]  S_RUN     = ST_RUN;
    localparam logic [1:0]  S_OVER    = ST_OVER;
    localparam logic [7:0]  GAP_LAST  = 8'(SPAWN_GAP - 1);
    localparam logic [15:0] KILL_LAST = 16'(KILLS_PER_LEVEL - 1);

    // Tick period for a level, floored at PERIOD_MIN. Done in signed int so
    // a large level*step cannot wrap around to a huge period.
    function automatic logic [15:0] period_for(input logic [3:0] lvl);
        int p;
        p = PERIOD_INIT - int'(lvl) * PERIOD_STEP;
        if (p < PERIOD_MIN) begin
            p = PERIOD_MIN;
        end
        return 16'(p);
    endfunction

    // First clear bit of busy, searched circularly starting at ptr.
    // Returns {found, index}.
    function automatic logic [4:0] first_free(input logic [MONSTERS-1:0] busy,
                                              input logic [3:0]          ptr);
        logic       found;
        logic [3:0] sel;
        logic [3:0] idx;
        found = 1'b0;
        sel   = 4'd0;
        for (int i = 0; i < MONSTERS; i++) begin
            idx = 4'((int'(ptr) + i) % MONSTERS);
            if (!found && !busy[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

    logic [1:0]  r_state;
    logic        r_active;
    logic [15:0] r_tick_cnt;
    logic        r_move_tick;
    logic        r_spawn_valid;
    logic [3:0]  r_spawn_slot;
    lane_t       r_spawn_lane;
    logic [15:0] r_score;
    logic [3:0]  r_level;
    logic [15:0] r_kill_cnt;
    logic [7:0]  r_gap;
    logic [3:0]  r_ptr;

    logic [15:0] w_lfsr;
    logic        w_unused_lfsr;
    logic        w_in_run;
    logic        w_fire;
    logic        w_attempt;
    logic [4:0]  w_search;
    logic        w_found;
    logic [3:0]  w_free_slot;
    logic [3:0]  w_next_ptr;

    lfsr16 #(
        .SEED (LFSR_SEED),
        .MASK (LFSR_MASK)
    ) u_lfsr (
        .i_clk   (clk_game),
        .i_rst   (rst),
        .o_state (w_lfsr)
    );

    // Only the two low bits pick the lane; the rest is free-running state.
    assign w_unused_lfsr = ^w_lfsr[15:2];

    assign w_in_run = (r_state == S_RUN);

    // move_tick is registered, so the tick is launched on the edge where the
    // counter steps 1 -> 0; the output is then high exactly while the counter
    // sits at 0. A hit in the same cycle suppresses it. slot_busy and the LFSR
    // are sampled on this launching edge.
    assign w_fire      = w_in_run && !hit && (r_tick_cnt == 16'd1);
    assign w_attempt   = w_fire && (r_gap == GAP_LAST);
    assign w_search    = first_free(slot_busy, r_ptr);
    assign w_found     = w_search[4];
    assign w_free_slot = w_search[3:0];
    assign w_next_ptr  = (w_free_slot == 4'(MONSTERS - 1)) ? 4'd0 : w_free_slot + 4'd1;

    always_ff @(posedge clk_game) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_active      <= 1'b0;
            r_tick_cnt    <= 16'd0;
            r_move_tick   <= 1'b0;
            r_spawn_valid <= 1'b0;
            r_spawn_slot  <= 4'd0;
            r_spawn_lane  <= 2'b00;
            r_score       <= 16'd0;
            r_level       <= 4'd0;
            r_kill_cnt    <= 16'd0;
            r_gap         <= 8'd0;
            r_ptr         <= 4'd0;
        end else begin
            r_move_tick   <= w_fire;
            r_spawn_valid <= w_attempt && w_found;

            case (r_state)
                S_RUN: begin
                    // A kill coinciding with hit still counts.
                    if (kill) begin
                        if (r_score != 16'hFFFF) begin
                            r_score <= r_score + 16'd1;
                        end
                        if (r_kill_cnt == KILL_LAST) begin
                            r_kill_cnt <= 16'd0;
                            if (r_level != 4'hF) begin
                                r_level <= r_level + 4'd1;
                            end
                        end else begin
                            r_kill_cnt <= r_kill_cnt + 16'd1;
                        end
                    end

                    if (hit) begin
                        r_state  <= S_OVER;
                        r_active <= 1'b0;
                    end

                    // Level changes only show up here, at the reload.
                    if (r_tick_cnt == 16'd0) begin
                        r_tick_cnt <= period_for(r_level) - 16'd1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt - 16'd1;
                    end

                    if (w_fire) begin
                        if (w_attempt) begin
                            // With every slot busy the gap stays at its
                            // threshold so the attempt repeats next tick.
                            if (w_found) begin
                                r_spawn_slot <= w_free_slot;
                                r_spawn_lane <= lane_t'(w_lfsr[1:0]);
                                r_gap        <= 8'd0;
                                r_ptr        <= w_next_ptr;
                            end
                        end else begin
                            r_gap <= r_gap + 8'd1;
                        end
                    end
                end

                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_active   <= 1'b1;
                        r_score    <= 16'd0;
                        r_level    <= 4'd0;
                        r_kill_cnt <= 16'd0;
                        r_gap      <= 8'd0;
                        r_ptr      <= 4'd0;
                        r_tick_cnt <= period_for(4'd0) - 16'd1;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign active      = r_active;
    assign move_tick   = r_move_tick;
    assign spawn_valid = r_spawn_valid;
    assign spawn_slot  = r_spawn_slot;
    assign spawn_lane  = r_spawn_lane;
    assign score       = r_score;
    assign level       = r_level;
    assign dbg_state   = r_state;

endmodule
